// File: rtl/commit_trace_pkg.sv
// Shared types for the commit trace buffer: record layout, store-size encoding
// and the widths used by the channel compaction logic.
package commit_trace_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REC_XLEN   = 64;   // fields sized for the widest supported XLEN
    localparam int K_W        = 3;    // holds 0..4 retires per cycle

    typedef enum logic [1:0] {
        MEM_NONE = 2'd0,
        MEM_BYTE = 2'd1,
        MEM_HALF = 2'd2,
        MEM_WORD = 2'd3
    } mem_op_e;

    typedef struct packed {
        logic [REC_XLEN-1:0]   pc;
        logic [REC_XLEN-1:0]   instr;
        logic [REG_ADDR_W-1:0] rd;
        logic                  rd_we;
        logic [REC_XLEN-1:0]   rd_wdata;
        mem_op_e               mem_op;
        logic [REC_XLEN-1:0]   mem_addr;
        logic [REC_XLEN-1:0]   mem_wdata;
        logic [31:0]           seq;
    } commit_rec_t;

endpackage

// File: rtl/commit_trace_compact.sv
// Packs sparse retire-channel valids into program-order slot offsets and
// returns the number of retires this cycle.
module commit_trace_compact
    import commit_trace_pkg::*;
#(
    parameter int NRET = 2
) (
    input  logic [NRET-1:0]          valid,
    output logic [NRET-1:0][K_W-1:0] offset,
    output logic [K_W-1:0]           k
);

    logic [K_W-1:0] acc;

    // Each channel's slot offset is the number of valid older channels.
    always_comb begin
        acc    = '0;
        offset = '0;
        for (int i = 0; i < NRET; i++) begin
            offset[i] = acc;
            acc       = acc + K_W'(valid[i]);
        end
        k = acc;
    end

endmodule

// File: rtl/commit_trace_buffer.sv
// Multi-channel retire trace FIFO (first-word-fall-through) with sequence
// tagging and drop accounting. Define COMMIT_TRACE_TIMESTAMP_EN for per-record timestamps.
module commit_trace_buffer
    import commit_trace_pkg::*;
#(
    parameter int NRET  = 2,
    parameter int DEPTH = 16,
    parameter int XLEN  = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NRET-1:0]            ret_valid,
    input  logic [NRET*XLEN-1:0]       ret_pc,
    input  logic [NRET*XLEN-1:0]       ret_instr,
    input  logic [NRET*REG_ADDR_W-1:0] ret_rd,
    input  logic [NRET-1:0]            ret_rd_we,
    input  logic [NRET*XLEN-1:0]       ret_rd_wdata,
    input  logic [NRET*2-1:0]          ret_mem_op,
    input  logic [NRET*XLEN-1:0]       ret_mem_addr,
    input  logic [NRET*XLEN-1:0]       ret_mem_wdata,
    input  logic                       flush,
    output logic                       in_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_pc,
    output logic [XLEN-1:0]            out_instr,
    output logic [REG_ADDR_W-1:0]      out_rd,
    output logic                       out_rd_we,
    output logic [XLEN-1:0]            out_rd_wdata,
    output logic [1:0]                 out_mem_op,
    output logic [XLEN-1:0]            out_mem_addr,
    output logic [XLEN-1:0]            out_mem_wdata,
    output logic [31:0]                out_seq,
    output logic [31:0]                out_ts,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic [15:0]                drop_count
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;

    logic [NRET-1:0][K_W-1:0] offset;
    logic [K_W-1:0]           k;

    commit_trace_compact #(.NRET(NRET)) u_compact (
        .valid  (ret_valid),
        .offset (offset),
        .k      (k)
    );

    commit_rec_t              mem [DEPTH];
    commit_rec_t [NRET-1:0]   rec_in;
    logic [NRET-1:0][ADDR_W-1:0] wr_idx;
    commit_rec_t              head;

    logic [ADDR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [31:0]       seq_reg;
    logic              overflow_reg;
    logic [15:0]       drop_reg;

    logic [CNT_W-1:0]  free_slots;
    logic              fits, push, drop, pop;
    logic [16:0]       drop_sum;

    assign free_slots = CNT_W'(DEPTH) - count_reg;
    assign fits       = int'(k) <= int'(free_slots);
    assign push       = !flush && fits && (k != '0);
    assign drop       = !flush && !fits;
    assign out_valid  = count_reg != '0;
    assign pop        = out_valid && out_ready;
    assign in_ready   = int'(free_slots) >= NRET;
    assign drop_sum   = {1'b0, drop_reg} + 17'(k);

    generate
        for (genvar gi = 0; gi < NRET; gi++) begin : g_chan
            assign wr_idx[gi] = wr_ptr_reg + ADDR_W'(offset[gi]);
        end
    endgenerate

    always_comb begin
        rec_in = '0;
        for (int i = 0; i < NRET; i++) begin
            rec_in[i].pc        = REC_XLEN'(ret_pc[i*XLEN +: XLEN]);
            rec_in[i].instr     = REC_XLEN'(ret_instr[i*XLEN +: XLEN]);
            rec_in[i].rd        = ret_rd[i*REG_ADDR_W +: REG_ADDR_W];
            rec_in[i].rd_we     = ret_rd_we[i];
            rec_in[i].rd_wdata  = REC_XLEN'(ret_rd_wdata[i*XLEN +: XLEN]);
            rec_in[i].mem_op    = mem_op_e'(ret_mem_op[i*2 +: 2]);
            rec_in[i].mem_addr  = REC_XLEN'(ret_mem_addr[i*XLEN +: XLEN]);
            rec_in[i].mem_wdata = REC_XLEN'(ret_mem_wdata[i*XLEN +: XLEN]);
            rec_in[i].seq       = seq_reg + 32'(offset[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            for (int i = 0; i < NRET; i++) begin
                if (ret_valid[i]) begin
                    mem[wr_idx[i]] <= rec_in[i];
                end
            end
        end
    end

    // Dropped groups still consume sequence numbers; flushed ones do not.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            seq_reg      <= '0;
            overflow_reg <= 1'b0;
            drop_reg     <= '0;
        end else begin
            if (!flush) begin
                seq_reg <= seq_reg + 32'(k);
            end
            if (flush) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
                count_reg  <= '0;
            end else begin
                if (push) begin
                    wr_ptr_reg <= wr_ptr_reg + ADDR_W'(k);
                end
                if (pop) begin
                    rd_ptr_reg <= rd_ptr_reg + 1'b1;
                end
                count_reg <= count_reg + (push ? CNT_W'(k) : '0) - (pop ? CNT_W'(1) : '0);
            end
            if (drop) begin
                overflow_reg <= 1'b1;
                drop_reg     <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            end
        end
    end

    always_comb begin
        head = '0;
        if (out_valid) begin
            head = mem[rd_ptr_reg];
        end
    end

    assign out_pc        = XLEN'(head.pc);
    assign out_instr     = XLEN'(head.instr);
    assign out_rd        = head.rd;
    assign out_rd_we     = head.rd_we;
    assign out_rd_wdata  = XLEN'(head.rd_wdata);
    assign out_mem_op    = head.mem_op;
    assign out_mem_addr  = XLEN'(head.mem_addr);
    assign out_mem_wdata = XLEN'(head.mem_wdata);
    assign out_seq       = head.seq;
    assign count         = count_reg;
    assign overflow      = overflow_reg;
    assign drop_count    = drop_reg;

`ifdef COMMIT_TRACE_TIMESTAMP_EN
    logic [31:0] ts_reg;
    logic [31:0] ts_mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_reg <= '0;
        end else begin
            ts_reg <= ts_reg + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            for (int i = 0; i < NRET; i++) begin
                if (ret_valid[i]) begin
                    ts_mem[wr_idx[i]] <= ts_reg;
                end
            end
        end
    end

    assign out_ts = out_valid ? ts_mem[rd_ptr_reg] : 32'd0;
`else
    assign out_ts = 32'd0;
`endif

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Self-checking bench for commit_trace_buffer: queue-based reference model
// compared every cycle, plus directed literal checks for the key scenarios.
`timescale 1ns/1ps
module tb_commit_trace_buffer;

    localparam int NRET  = 2;
    localparam int DEPTH = 16;
    localparam int XLEN  = 32;

`ifdef COMMIT_TRACE_TIMESTAMP_EN
    localparam logic [31:0] TS_A = 32'd3;
    localparam logic [31:0] TS_B = 32'd10;
`else
    localparam logic [31:0] TS_A = 32'd0;
    localparam logic [31:0] TS_B = 32'd0;
`endif

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NRET-1:0]       ret_valid = '0;
    logic [NRET*XLEN-1:0]  ret_pc = '0, ret_instr = '0, ret_rd_wdata = '0;
    logic [NRET*XLEN-1:0]  ret_mem_addr = '0, ret_mem_wdata = '0;
    logic [NRET*5-1:0]     ret_rd = '0;
    logic [NRET-1:0]       ret_rd_we = '0;
    logic [NRET*2-1:0]     ret_mem_op = '0;
    logic                  flush = 1'b0;
    logic                  out_ready = 1'b0;
    logic                  in_ready, out_valid, out_rd_we, overflow;
    logic [XLEN-1:0]       out_pc, out_instr, out_rd_wdata, out_mem_addr, out_mem_wdata;
    logic [4:0]            out_rd;
    logic [1:0]            out_mem_op;
    logic [31:0]           out_seq, out_ts;
    logic [4:0]            count;
    logic [15:0]           drop_count;

    commit_trace_buffer #(.NRET(NRET), .DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .ret_valid(ret_valid), .ret_pc(ret_pc),
        .ret_instr(ret_instr), .ret_rd(ret_rd), .ret_rd_we(ret_rd_we),
        .ret_rd_wdata(ret_rd_wdata), .ret_mem_op(ret_mem_op),
        .ret_mem_addr(ret_mem_addr), .ret_mem_wdata(ret_mem_wdata),
        .flush(flush), .in_ready(in_ready), .out_valid(out_valid),
        .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
        .out_rd(out_rd), .out_rd_we(out_rd_we), .out_rd_wdata(out_rd_wdata),
        .out_mem_op(out_mem_op), .out_mem_addr(out_mem_addr),
        .out_mem_wdata(out_mem_wdata), .out_seq(out_seq), .out_ts(out_ts),
        .count(count), .overflow(overflow), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc, instr, rd_wdata, mem_addr, mem_wdata, seq, ts;
        logic [4:0]  rd;
        logic        rd_we;
        logic [1:0]  mem_op;
    } rec_t;

    rec_t        q[$];
    logic [31:0] m_seq = '0;
    logic [31:0] m_ts = '0;
    int          m_drops = 0;
    logic        m_ovf = 1'b0;
    int          total = 0;
    int          bad = 0;
    int unsigned uid = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic rec_t mk_rec(input int i, input logic [31:0] seq, input logic [31:0] ts);
        rec_t r;
        r.pc        = ret_pc[i*32 +: 32];
        r.instr     = ret_instr[i*32 +: 32];
        r.rd        = ret_rd[i*5 +: 5];
        r.rd_we     = ret_rd_we[i];
        r.rd_wdata  = ret_rd_wdata[i*32 +: 32];
        r.mem_op    = ret_mem_op[i*2 +: 2];
        r.mem_addr  = ret_mem_addr[i*32 +: 32];
        r.mem_wdata = ret_mem_wdata[i*32 +: 32];
        r.seq       = seq;
`ifdef COMMIT_TRACE_TIMESTAMP_EN
        r.ts        = ts;
`else
        r.ts        = 32'd0 & ts;
`endif
        return r;
    endfunction

    // Reference model: an ordered queue of records plus plain counters.
    always @(posedge clk or posedge rst) begin : model
        int k;
        int free;
        bit pop;
        if (rst) begin
            q.delete();
            m_seq   = '0;
            m_ts    = '0;
            m_drops = 0;
            m_ovf   = 1'b0;
        end else begin
            k = 0;
            for (int i = 0; i < NRET; i++) k += int'(ret_valid[i]);
            pop  = (q.size() != 0) && out_ready;
            free = DEPTH - q.size();
            if (flush) begin
                q.delete();
            end else begin
                if (pop) void'(q.pop_front());
                if (k <= free) begin
                    for (int i = 0; i < NRET; i++) begin
                        if (ret_valid[i]) begin
                            q.push_back(mk_rec(i, m_seq, m_ts));
                            m_seq = m_seq + 1;
                        end
                    end
                end else begin
                    m_ovf   = 1'b1;
                    m_drops = (m_drops + k > 65535) ? 65535 : m_drops + k;
                    m_seq   = m_seq + 32'(k);
                end
            end
            m_ts = m_ts + 1;
        end
    end

    always @(negedge clk) begin : compare
        chk("count", 32'(count), 32'(q.size()));
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        chk("in_ready", 32'(in_ready), 32'((DEPTH - q.size()) >= NRET));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("drop_count", 32'(drop_count), 32'(m_drops));
        if (q.size() != 0) begin
            chk("out_pc", out_pc, q[0].pc);
            chk("out_instr", out_instr, q[0].instr);
            chk("out_rd", 32'(out_rd), 32'(q[0].rd));
            chk("out_rd_we", 32'(out_rd_we), 32'(q[0].rd_we));
            chk("out_rd_wdata", out_rd_wdata, q[0].rd_wdata);
            chk("out_mem_op", 32'(out_mem_op), 32'(q[0].mem_op));
            chk("out_mem_addr", out_mem_addr, q[0].mem_addr);
            chk("out_mem_wdata", out_mem_wdata, q[0].mem_wdata);
            chk("out_seq", out_seq, q[0].seq);
            chk("out_ts", out_ts, q[0].ts);
        end
    end

    // Applies one cycle of inputs with fresh per-channel payloads.
    task automatic drive(input logic [1:0] v, input logic r, input logic f);
        logic [31:0] u;
        ret_valid = v;
        out_ready = r;
        flush     = f;
        for (int i = 0; i < NRET; i++) begin
            u = uid;
            uid++;
            ret_pc[i*32 +: 32]        = 32'h8000_0000 + u * 4;
            ret_instr[i*32 +: 32]     = (u * 32'h9E37_79B1) ^ 32'h13;
            ret_rd[i*5 +: 5]          = u[4:0];
            ret_rd_we[i]              = u[0];
            ret_rd_wdata[i*32 +: 32]  = ~(u * 32'h0101_0101);
            ret_mem_op[i*2 +: 2]      = u[2:1];
            ret_mem_addr[i*32 +: 32]  = 32'h2000_0000 ^ (u << 3);
            ret_mem_wdata[i*32 +: 32] = u * 7 + 32'hA5;
        end
        @(negedge clk);
        $display("cycle v=%b rdy=%b fl=%b -> count=%0d out_valid=%b out_seq=%0d ovf=%b drops=%0d",
                 v, r, f, count, out_valid, out_seq, overflow, drop_count);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_drop", 32'(drop_count), 32'd0);
        chk("rst_out_pc", out_pc, 32'd0);
        rst = 1'b0;

        // Two retires per cycle, streaming out
        drive(2'b11, 1'b1, 1'b0);
        chk("s1_count1", 32'(count), 32'd2);
        chk("s1_seq1", out_seq, 32'd0);
        drive(2'b11, 1'b1, 1'b0);
        chk("s1_seq2", out_seq, 32'd1);
        drive(2'b11, 1'b1, 1'b0);
        chk("s1_count3", 32'(count), 32'd4);
        chk("s1_seq3", out_seq, 32'd2);
        repeat (4) drive(2'b00, 1'b1, 1'b0);
        chk("s1_drained", 32'(count), 32'd0);

        // Sparse valid: only channel 1
        drive(2'b10, 1'b1, 1'b0);
        chk("s2_count", 32'(count), 32'd1);
        chk("s2_seq", out_seq, 32'd6);
        chk("s2_pc_ch1", out_pc, ret_pc[63:32]);
        drive(2'b00, 1'b1, 1'b0);

        // Fill to full, then overflow
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (7) drive(2'b11, 1'b0, 1'b0);
        chk("s3_ready14", 32'(in_ready), 32'd1);
        drive(2'b11, 1'b0, 1'b0);
        chk("s3_full", 32'(count), 32'd16);
        chk("s3_not_ready", 32'(in_ready), 32'd0);
        drive(2'b11, 1'b0, 1'b0);
        chk("s3_overflow", 32'(overflow), 32'd1);
        chk("s3_drop", 32'(drop_count), 32'd2);
        chk("s3_count", 32'(count), 32'd16);
        repeat (15) drive(2'b00, 1'b1, 1'b0);
        chk("s3_last_seq", out_seq, 32'd15);
        drive(2'b11, 1'b1, 1'b0);
        chk("s3_jump_seq", out_seq, 32'd18);
        repeat (2) drive(2'b00, 1'b1, 1'b0);

        // Flush concurrent with a push
        drive(2'b11, 1'b0, 1'b0);
        drive(2'b11, 1'b0, 1'b0);
        drive(2'b01, 1'b0, 1'b0);
        chk("s4_count5", 32'(count), 32'd5);
        drive(2'b11, 1'b0, 1'b1);
        chk("s4_flushed", 32'(count), 32'd0);
        drive(2'b01, 1'b0, 1'b0);
        chk("s4_next_seq", out_seq, 32'd25);
        chk("s4_drop_kept", 32'(drop_count), 32'd2);

        // Asynchronous reset mid-operation
        repeat (3) drive(2'b11, 1'b0, 1'b0);
        chk("s5_count7", 32'(count), 32'd7);
        #2 rst = 1'b1;
        #1;
        chk("s5_arst_count", 32'(count), 32'd0);
        chk("s5_arst_valid", 32'(out_valid), 32'd0);
        chk("s5_arst_ready", 32'(in_ready), 32'd1);
        chk("s5_arst_ovf", 32'(overflow), 32'd0);
        chk("s5_arst_drop", 32'(drop_count), 32'd0);
        chk("s5_arst_pc", out_pc, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(2'b01, 1'b1, 1'b0);
        chk("s5_seq0", out_seq, 32'd0);
        drive(2'b00, 1'b1, 1'b0);

        // Timestamps at cycles 3 and 10 after reset
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) drive(2'b00, 1'b0, 1'b0);
        drive(2'b01, 1'b0, 1'b0);
        repeat (6) drive(2'b00, 1'b0, 1'b0);
        drive(2'b01, 1'b0, 1'b0);
        chk("s6_ts_a", out_ts, TS_A);
        drive(2'b00, 1'b1, 1'b0);
        chk("s6_ts_b", out_ts, TS_B);
        drive(2'b00, 1'b1, 1'b0);
        chk("s6_empty", 32'(count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/commit_trace_buffer.md
# commit_trace_buffer

Captures per-cycle instruction retirement events from up to NRET retire channels of the RISC-V core, compacts them into program order, tags each with a sequence number, and serialises them one record per cycle over a valid/ready stream. It sits between the core's retire stage and the UVM commit monitor, which steps the instruction set model once per record and compares register-write and memory-write effects. It replaces single-retire, single-cycle trace sampling with a multi-channel, buffered, loss-detecting interface.

## Interface
- NRET, 2: retire channels per cycle (1..4); lower index is older.
- DEPTH, 16: record slots; power of two, at least 2*NRET.
- XLEN, 32: data/address width.
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- ret_valid  in  NRET  channel i retired an instruction this cycle.
- ret_pc, ret_instr  in  NRET*XLEN each  PC and instruction word per channel.
- ret_rd  in  NRET*5  destination register.
- ret_rd_we  in  NRET  register write performed.
- ret_rd_wdata  in  NRET*XLEN  register write data.
- ret_mem_op  in  NRET*2  0 none, 1 byte, 2 halfword, 3 word store.
- ret_mem_addr, ret_mem_wdata  in  NRET*XLEN each  store address/data.
- flush  in  1  discard all buffered records.
- in_ready  out  1  free slots >= NRET.
- out_valid  out  1  head record available.
- out_ready  in  1  consumer accepts head.
- out_pc, out_instr, out_rd, out_rd_we, out_rd_wdata, out_mem_op, out_mem_addr, out_mem_wdata  out  field widths as above  head record.
- out_seq  out  32  sequence number of head record.
- out_ts  out  32  capture cycle of head record.
- count  out  $clog2(DEPTH)+1  records held.
- overflow  out  1  sticky: a retire group was dropped.
- drop_count  out  16  records dropped, saturating.

## Operation
- Compaction: valid channels packed in ascending index order; sparse valid patterns (e.g. only channel 1) allowed.
- ret_rd_we with ret_rd = 0 is stored as given; no filtering.
- Push: k = popcount(ret_valid). If k <= free slots at start of cycle, all k written. Otherwise none written; overflow set; drop_count += k (saturating at 0xFFFF).
- Free-slot check ignores a same-cycle pop.
- Sequence counter: assigned per valid record in compaction order, accepted or dropped; wraps 2^32 to 0. A dropped group appears as a gap in out_seq.
- Pop: out_valid && out_ready advances the head. out_* are don't-care while out_valid = 0.
- FIFO is first-word-fall-through: out_valid = (count != 0).
- Simultaneous push and pop: both happen; count += k - 1.
- Flush: count and pointers cleared in that cycle; same-cycle push discarded without counting as drop and without consuming sequence numbers. overflow, drop_count and the sequence counter are unaffected.
- Pointers wrap modulo DEPTH.

## Timing
- Record accepted at edge N is visible on out_* with out_valid = 1 after edge N (zero-bubble when empty).
- Throughput: NRET in per cycle, 1 out per cycle.
- in_ready is combinational from count; registered state only.
- Reset values: count 0, out_valid 0, in_ready 1, overflow 0, drop_count 0, sequence counter 0, timestamp counter 0, out_* 0.
- Reset mid-operation clears all contents immediately; there is no drain.

## Configuration
- COMMIT_TRACE_TIMESTAMP_EN defined: a 32-bit free-running cycle counter (0 after reset, wraps) is stored per record and driven on out_ts.
- Undefined: no counter or storage; out_ts tied to 0.

## Structure
- commit_trace_pkg: commit_rec_t packed struct, mem_op_e enum (MEM_NONE, MEM_BYTE, MEM_HALF, MEM_WORD), REG_ADDR_W = 5.
- Sub-module commit_trace_compact: combinational packing of valid channels into slot offsets and popcount k. Storage, pointers and counters stay in the top module.

## Test plan
- NRET=2, DEPTH=16, both channels valid for 3 cycles with out_ready=1 -> 6 records out in channel order, out_seq 0..5, no overflow.
- ret_valid=2'b10 only -> one record carrying channel 1 fields, out_seq increments by 1.
- out_ready=0, 8 cycles of 2 retires -> count 16, in_ready 0; 9th group dropped, overflow=1, drop_count=2; after draining, out_seq jumps from 15 to 18.
- count=5 with flush and push in the same cycle -> count 0 next cycle; following push gets the next unconsumed sequence number; drop_count unchanged.
- rst asserted with count=7 -> all outputs at reset values immediately; post-reset record gets out_seq 0.
- With COMMIT_TRACE_TIMESTAMP_EN, push at cycles 3 and 10 after reset -> out_ts 3 and 10.
